// File: rtl/ctrl_pkg.sv
// Shared types for the ID/EX control stage: opcodes, control enums and the
// registered control bundle.
package ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10,
        RES_IMM = 2'b11
    } resultSrc_t;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_J = 3'b011,
        IMM_U = 3'b100
    } immSrc_t;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } aluOp_t;

    typedef struct packed {
        logic       reg_write;
        logic       mem_write;
        logic       mem_read;
        logic       branch;
        logic       jump;
        logic       jalr;
        logic       alu_src;
        logic       alu_src_a;
        resultSrc_t result_src;
        aluOp_t     alu_op;
        logic [2:0] funct3;
        logic       funct7b5;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
    } ctrl_t;

endpackage

// File: rtl/id_ex_ctrl_stage_if.sv
// ID-side inputs and EX-side control outputs of the control stage.
// valid_d / valid_e qualify their stage: when low, the rest of that stage is don't-care.
interface id_ex_ctrl_stage_if #(parameter int CNT_W = 8);

    logic [31:0]      instr_d;
    logic             valid_d;
    logic             flush_e;
    logic [2:0]       immSrc_d;
    logic             illegal_d;
    logic             stall_f;
    logic             stall_d;
    logic             regWrite_e;
    logic             memWrite_e;
    logic             memRead_e;
    logic             branch_e;
    logic             jump_e;
    logic             jalr_e;
    logic             ALUSrc_e;
    logic             ALUSrcA_e;
    logic [1:0]       resultSrc_e;
    logic [1:0]       ALUOp_e;
    logic [2:0]       funct3_e;
    logic             funct7b5_e;
    logic [4:0]       rs1_e;
    logic [4:0]       rs2_e;
    logic [4:0]       rd_e;
    logic             valid_e;
    logic [CNT_W-1:0] illegal_cnt;

    modport master (
        output instr_d, valid_d, flush_e,
        input  immSrc_d, illegal_d, stall_f, stall_d,
        input  regWrite_e, memWrite_e, memRead_e, branch_e, jump_e, jalr_e,
        input  ALUSrc_e, ALUSrcA_e, resultSrc_e, ALUOp_e, funct3_e, funct7b5_e,
        input  rs1_e, rs2_e, rd_e, valid_e, illegal_cnt
    );

    modport slave (
        input  instr_d, valid_d, flush_e,
        output immSrc_d, illegal_d, stall_f, stall_d,
        output regWrite_e, memWrite_e, memRead_e, branch_e, jump_e, jalr_e,
        output ALUSrc_e, ALUSrcA_e, resultSrc_e, ALUOp_e, funct3_e, funct7b5_e,
        output rs1_e, rs2_e, rd_e, valid_e, illegal_cnt
    );

endinterface

// File: rtl/op_decoder.sv
// Combinational opcode decode into the control bundle, extend select and
// register-use flags for the hazard check.
module op_decoder
    import ctrl_pkg::*;
#(
    parameter bit EN_JALR  = 1'b1,
    parameter bit EN_UPPER = 1'b1
) (
    input  logic [31:0] instr,
    input  logic        valid,
    output ctrl_t       ctrl,
    output immSrc_t     imm_src,
    output logic        illegal,
    output logic        uses_rs1,
    output logic        uses_rs2
);

    logic supported;
    logic unused_bits;

    assign unused_bits = ^{instr[31], instr[29:25]};

    always_comb begin
        ctrl      = '0;
        imm_src   = IMM_I;
        supported = 1'b0;
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        unique case (instr[6:0])
            OP_LOAD: begin
                supported       = 1'b1;
                uses_rs1        = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.result_src = RES_MEM;
            end
            OP_STORE: begin
                supported      = 1'b1;
                uses_rs1       = 1'b1;
                uses_rs2       = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                imm_src        = IMM_S;
            end
            OP_RTYPE: begin
                supported      = 1'b1;
                uses_rs1       = 1'b1;
                uses_rs2       = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_op    = ALU_FUNCT;
            end
            OP_ITYPE: begin
                supported      = 1'b1;
                uses_rs1       = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
                ctrl.alu_op    = ALU_FUNCT;
            end
            OP_BRANCH: begin
                supported   = 1'b1;
                uses_rs1    = 1'b1;
                uses_rs2    = 1'b1;
                ctrl.branch = 1'b1;
                ctrl.alu_op = ALU_SUB;
                imm_src     = IMM_B;
            end
            OP_JAL: begin
                supported       = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.jump       = 1'b1;
                ctrl.result_src = RES_PC4;
                imm_src         = IMM_J;
            end
            OP_JALR: if (EN_JALR) begin
                supported       = 1'b1;
                uses_rs1        = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.jalr       = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.result_src = RES_PC4;
            end
            OP_LUI: if (EN_UPPER) begin
                supported       = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.result_src = RES_IMM;
                imm_src         = IMM_U;
            end
            OP_AUIPC: if (EN_UPPER) begin
                supported      = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src   = 1'b1;
                imm_src        = IMM_U;
            end
            default: ;
        endcase
        // Fields ride along only for real instructions so an illegal one leaves EX all-zero.
        if (supported) begin
            ctrl.funct3   = instr[14:12];
            ctrl.funct7b5 = instr[30];
            ctrl.rs1      = instr[19:15];
            ctrl.rs2      = instr[24:20];
            ctrl.rd       = instr[11:7];
        end
    end

    assign illegal = valid & ~supported;

endmodule

// File: rtl/id_ex_ctrl_stage.sv
// ID/EX control stage: decode, load-use hazard detection, bubble insertion
// and a saturating illegal-instruction counter.
module id_ex_ctrl_stage
    import ctrl_pkg::*;
#(
    parameter bit EN_JALR  = 1'b1,
    parameter bit EN_UPPER = 1'b1,
    parameter int CNT_W    = 8
) (
    input  logic                clk,
    input  logic                reset,
    id_ex_ctrl_stage_if.slave   bus
);

    ctrl_t            dec_ctrl;
    immSrc_t          dec_imm_src;
    logic             dec_illegal;
    logic             uses_rs1;
    logic             uses_rs2;
    logic             hazard;

    ctrl_t            ctrl_e_d,      ctrl_e_q;
    logic             valid_e_d,     valid_e_q;
    logic [CNT_W-1:0] illegal_cnt_d, illegal_cnt_q;

    op_decoder #(
        .EN_JALR  (EN_JALR),
        .EN_UPPER (EN_UPPER)
    ) u_dec (
        .instr    (bus.instr_d),
        .valid    (bus.valid_d),
        .ctrl     (dec_ctrl),
        .imm_src  (dec_imm_src),
        .illegal  (dec_illegal),
        .uses_rs1 (uses_rs1),
        .uses_rs2 (uses_rs2)
    );

    assign hazard = valid_e_q & ctrl_e_q.mem_read & (ctrl_e_q.rd != 5'd0) & bus.valid_d &
                    ((uses_rs1 & (bus.instr_d[19:15] == ctrl_e_q.rd)) |
                     (uses_rs2 & (bus.instr_d[24:20] == ctrl_e_q.rd)));

    always_comb begin
        ctrl_e_d      = dec_ctrl;
        valid_e_d     = bus.valid_d & ~dec_illegal;
        illegal_cnt_d = illegal_cnt_q;
        if (bus.flush_e | hazard) begin
            ctrl_e_d  = '0;
            valid_e_d = 1'b0;
        end else if (dec_illegal && illegal_cnt_q != {CNT_W{1'b1}}) begin
            illegal_cnt_d = illegal_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_e_q      <= '0;
            valid_e_q     <= 1'b0;
            illegal_cnt_q <= '0;
        end else begin
            ctrl_e_q      <= ctrl_e_d;
            valid_e_q     <= valid_e_d;
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    // A flush squashes ID anyway, so holding the front end would only waste a cycle.
    assign bus.stall_f     = hazard & ~bus.flush_e;
    assign bus.stall_d     = hazard & ~bus.flush_e;
    assign bus.immSrc_d    = dec_imm_src;
    assign bus.illegal_d   = dec_illegal;

    assign bus.regWrite_e  = ctrl_e_q.reg_write;
    assign bus.memWrite_e  = ctrl_e_q.mem_write;
    assign bus.memRead_e   = ctrl_e_q.mem_read;
    assign bus.branch_e    = ctrl_e_q.branch;
    assign bus.jump_e      = ctrl_e_q.jump;
    assign bus.jalr_e      = ctrl_e_q.jalr;
    assign bus.ALUSrc_e    = ctrl_e_q.alu_src;
    assign bus.ALUSrcA_e   = ctrl_e_q.alu_src_a;
    assign bus.resultSrc_e = ctrl_e_q.result_src;
    assign bus.ALUOp_e     = ctrl_e_q.alu_op;
    assign bus.funct3_e    = ctrl_e_q.funct3;
    assign bus.funct7b5_e  = ctrl_e_q.funct7b5;
    assign bus.rs1_e       = ctrl_e_q.rs1;
    assign bus.rs2_e       = ctrl_e_q.rs2;
    assign bus.rd_e        = ctrl_e_q.rd;
    assign bus.valid_e     = valid_e_q;
    assign bus.illegal_cnt = illegal_cnt_q;

endmodule

// File: doc/id_ex_ctrl_stage.md
# id_ex_ctrl_stage

Pipelined control stage for the five-stage RV32I core. It decodes the instruction in ID into a full control bundle and registers it into the ID/EX boundary. It detects load-use hazards and generates the fetch/decode stalls, and inserts bubbles on stall or EX-stage flush. It extends base decode with optional JALR/LUI/AUIPC support and counts illegal opcodes.

## Interface
- EN_JALR, 1, decode opcode 1100111 (JALR); 0 makes it illegal
- EN_UPPER, 1, decode LUI (0110111) and AUIPC (0010111); 0 makes them illegal
- CNT_W, 8, width of the saturating illegal-instruction counter

Ports:
- clk  in  1  core clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- instr_d  in  32  instruction word in ID
- valid_d  in  1  instr_d holds a real instruction
- flush_e  in  1  branch/jump taken in EX; squash the instruction entering EX
- immSrc_d  out  3  combinational extend select for ID: 000 I, 001 S, 010 B, 011 J, 100 U
- illegal_d  out  1  combinational; valid_d and the opcode is unsupported
- stall_f, stall_d  out  1 each  combinational load-use stall, same value
- regWrite_e, memWrite_e, memRead_e, branch_e, jump_e, jalr_e, ALUSrc_e, ALUSrcA_e  out  1 each  registered controls
- resultSrc_e  out  2  00 ALU, 01 memory, 10 PC+4, 11 immediate
- ALUOp_e  out  2  00 add, 01 subtract/compare, 10 funct-decoded
- funct3_e  out  3  registered instr[14:12]
- funct7b5_e  out  1  registered instr[30]
- rs1_e, rs2_e, rd_e  out  5 each  registered register addresses
- valid_e  out  1  EX holds a real instruction
- illegal_cnt  out  CNT_W  number of illegal instructions, saturating

## Operation
- Decode (combinational) per opcode:
  - lw: regWrite, memRead, ALUSrc, resultSrc 01, immSrc I
  - sw: memWrite, ALUSrc, immSrc S
  - R-type: regWrite, ALUOp 10
  - I-ALU: regWrite, ALUSrc, ALUOp 10, immSrc I
  - beq: branch, ALUOp 01, immSrc B
  - jal: regWrite, jump, resultSrc 10, immSrc J
  - jalr: regWrite, jalr, ALUSrc, resultSrc 10, immSrc I
  - lui: regWrite, resultSrc 11, immSrc U
  - auipc: regWrite, ALUSrcA, ALUSrc, immSrc U
  - Every unlisted control is 0.
- Unsupported or disabled opcode with valid_d=1:
  - illegal_d=1
  - bundle is all-zero and valid_e is loaded 0
- Register-use rules for hazard checks:
  - rs1 is used by all formats except jal, lui and auipc.
  - rs2 is used only by R-type, sw and beq.
- Hazard: hazard = valid_e & memRead_e & (rd_e≠0) & valid_d & ((uses_rs1 & rs1_d==rd_e) | (uses_rs2 & rs2_d==rd_e)).
- Stall: stall_f = stall_d = hazard & ~flush_e.
- ID/EX update at each clock edge, in priority order:
  1. flush_e or hazard: load a bubble (all controls, addresses and fields 0; valid_e 0).
  2. Otherwise: load the decoded bundle, with valid_e = valid_d & ~illegal_d.
- illegal_cnt increments by 1 when illegal_d & ~flush_e & ~hazard. It holds at 2^CNT_W−1 once reached.

## Timing
- Reset value of every registered output is 0, including illegal_cnt. It takes effect asynchronously and is released synchronously by the clock.
- Decode-to-EX latency: 1 cycle.
- immSrc_d, illegal_d and stalls are same-cycle combinational outputs.
- A load-use stall lasts exactly 1 cycle: the bubble clears memRead_e, so hazard drops.
- flush_e together with hazard: bubble loaded, stall_f/stall_d=0. The front end discards ID.
- Reset asserted mid-stall: all outputs go to 0 immediately. The next instruction decodes normally after release.

## Structure
- Package ctrl_pkg holds:
  - opcode localparams
  - resultSrc_t, immSrc_t and aluOp_t enums
  - packed struct ctrl_t (the full control bundle)
- Sub-module op_decoder holds the combinational decode: opcode plus EN_* parameters in, ctrl_t, immSrc and illegal out.
- The top level contains the hazard logic, the ID/EX register and the counter.

## Test plan
- lw x5,0(x1) then add x6,x5,x2 → stall_d=1 for exactly 1 cycle, one bubble in EX (valid_e=0), then add appears with rs1_e=5.
- lw x0,0(x1) then add x6,x0,x2 → no stall.
- lw x5 then sw x5,0(x3) (rs2 match) → 1-cycle stall.
- lw x5 then jal x1 → no stall.
- Hazard plus flush_e=1 in the same cycle → stall_d=0, bubble loaded, illegal_cnt unchanged.
- CNT_W=2, five consecutive opcode 1111111 → illegal_cnt 1,2,3,3,3; valid_e=0 each cycle.
- EN_UPPER=0, lui → illegal_d=1. EN_UPPER=1, lui → resultSrc_e=11, regWrite_e=1.
- Assert reset while a stall is active → all outputs 0 immediately. After release, beq decodes with branch_e=1, ALUOp_e=01.
